div_axis_responder: RTL and testbench



---
 rtl/div_axis_responder_if.sv | 32 +++
 rtl/div_axis_responder.sv | 105 ++++++++++
 tb/tb_div_axis_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/div_axis_responder_if.sv
// div_axis_responder_if: operand/result bundle between the ALU division initiator and the divider.
//   dividend/divisor channels: tdata, tvalid (initiator -> divider), tready (divider -> initiator)
//   dout channel: tdata {quotient, remainder}, tvalid pulse (divider -> initiator, no backpressure)
interface div_axis_responder_if #(
    parameter int DW = 33,
    parameter int FW = 40
);
    logic [DW-1:0]   s_axis_dividend_tdata;
    logic            s_axis_dividend_tvalid;
    logic            s_axis_dividend_tready;
    logic [DW-1:0]   s_axis_divisor_tdata;
    logic            s_axis_divisor_tvalid;
    logic            s_axis_divisor_tready;
    logic [2*FW-1:0] m_axis_dout_tdata;
    logic            m_axis_dout_tvalid;

    modport slave (
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_dividend_tready,
        input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
        output s_axis_divisor_tready,
        output m_axis_dout_tdata, m_axis_dout_tvalid
    );

    modport master (
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_dividend_tready,
        output s_axis_divisor_tdata, s_axis_divisor_tvalid,
        input  s_axis_divisor_tready,
        input  m_axis_dout_tdata, m_axis_dout_tvalid
    );
endinterface

// File: rtl/div_axis_responder.sv
// div_axis_responder: multi-cycle signed radix-2 restoring divider with AXI-Stream style operand/result channels.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of div_axis_responder_if (dividend, divisor in; {quotient, remainder} out)
module div_axis_responder #(
    parameter int DW = 33,
    parameter int FW = 40
) (
    input logic                   clk,
    input logic                   reset,
    div_axis_responder_if.slave   bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q;
    logic [DW-1:0]   ha_q, hb_q;
    logic            afull_q, bfull_q;
    logic [DW-1:0]   qa_q, bm_q;
    logic [DW:0]     rem_q;
    logic [CW-1:0]   cnt_q;
    logic            qsign_q, rsign_q, bzero_q;
    logic [2*FW-1:0] dout_q;
    logic            valid_q;

    logic [DW-1:0]   amag_d, bmag_d;
    logic [DW:0]     sh_d, qs_d, rs_d;
    logic [DW+1:0]   diff_d;

    // A DW-bit unsigned magnitude is enough: 0 - (-2^(DW-1)) wraps to 2^(DW-1) exactly.
    assign amag_d = ha_q[DW-1] ? DW'(0) - ha_q : ha_q;
    assign bmag_d = hb_q[DW-1] ? DW'(0) - hb_q : hb_q;
    // qa_q starts as |a| and fills with quotient bits as the dividend shifts out of its top.
    assign sh_d   = {rem_q[DW-1:0], qa_q[DW-1]};
    assign diff_d = {1'b0, sh_d} - {2'b0, bm_q};
    assign qs_d   = qsign_q ? (DW+1)'(0) - {1'b0, qa_q} : {1'b0, qa_q};
    assign rs_d   = rsign_q ? (DW+1)'(0) - rem_q : rem_q;

    assign bus.s_axis_dividend_tready = ~afull_q & ~reset;
    assign bus.s_axis_divisor_tready  = ~bfull_q & ~reset;
    assign bus.m_axis_dout_tdata      = dout_q;
    assign bus.m_axis_dout_tvalid     = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ha_q    <= '0;
            hb_q    <= '0;
            afull_q <= 1'b0;
            bfull_q <= 1'b0;
            qa_q    <= '0;
            bm_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            bzero_q <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (bus.s_axis_dividend_tvalid && !afull_q) begin
                ha_q    <= bus.s_axis_dividend_tdata;
                afull_q <= 1'b1;
            end
            if (bus.s_axis_divisor_tvalid && !bfull_q) begin
                hb_q    <= bus.s_axis_divisor_tdata;
                bfull_q <= 1'b1;
            end
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Loading needs both slots full, so no capture can coincide with this clear.
                    if (afull_q && bfull_q) begin
                        afull_q <= 1'b0;
                        bfull_q <= 1'b0;
                        qa_q    <= amag_d;
                        bm_q    <= bmag_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        qsign_q <= ha_q[DW-1] ^ hb_q[DW-1];
                        rsign_q <= ha_q[DW-1];
                        bzero_q <= (hb_q == '0);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= diff_d[DW+1] ? sh_d : diff_d[DW:0];
                    qa_q  <= {qa_q[DW-2:0], ~diff_d[DW+1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW-1))
                        state_q <= FIX;
                end
                FIX: begin
                    // With b = 0 the remainder path already yields a; only the quotient is forced.
                    dout_q  <= {bzero_q ? {FW{1'b1}} : {{(FW-DW-1){qs_d[DW]}}, qs_d},
                                {{(FW-DW-1){rs_d[DW]}}, rs_d}};
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_axis_responder.sv
// tb_div_axis_responder: table-driven and sequence checks of div_axis_responder with a result scoreboard.
module tb_div_axis_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [32:0] a;
        logic [32:0] b;
        logic [39:0] q;
        logic [39:0] r;
    } vec_t;

    typedef struct {
        logic [39:0] q;
        logic [39:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tv[14];

    div_axis_responder_if #(.DW(33), .FW(40)) bus();

    div_axis_responder #(.DW(33), .FW(40)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.m_axis_dout_tvalid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tvalid got=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 64'(bus.m_axis_dout_tdata[79:40]), 64'(e.q));
                chk("remainder", 64'(bus.m_axis_dout_tdata[39:0]), 64'(e.r));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic send(input logic da, input logic db, input logic [32:0] a, input logic [32:0] b, output int hc);
        int n;
        n = 0;
        @(negedge clk);
        while (((da && !bus.s_axis_dividend_tready) || (db && !bus.s_axis_divisor_tready)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("tready_timeout", 64'd0, 64'd1);
        bus.s_axis_dividend_tvalid = da;
        bus.s_axis_divisor_tvalid  = db;
        if (da) bus.s_axis_dividend_tdata = a;
        if (db) bus.s_axis_divisor_tdata  = b;
        hc = cyc;
        @(negedge clk);
        bus.s_axis_dividend_tvalid = 1'b0;
        bus.s_axis_divisor_tvalid  = 1'b0;
        bus.s_axis_dividend_tdata  = '1;
        bus.s_axis_divisor_tdata   = '1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("result_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hc, h2;
        tv[0]  = '{33'd100, 33'd7, 40'd14, 40'd2};
        tv[1]  = '{-33'sd100, 33'd7, 40'hFF_FFFF_FFF2, 40'hFF_FFFF_FFFE};
        tv[2]  = '{33'd100, -33'sd7, 40'hFF_FFFF_FFF2, 40'd2};
        tv[3]  = '{-33'sd100, -33'sd7, 40'd14, 40'hFF_FFFF_FFFE};
        tv[4]  = '{33'h0_FFFF_FFFF, 33'd2, 40'h00_7FFF_FFFF, 40'd1};
        tv[5]  = '{33'h1_0000_0000, 33'h1_FFFF_FFFF, 40'h01_0000_0000, 40'd0};
        tv[6]  = '{33'd5, 33'd0, 40'hFF_FFFF_FFFF, 40'd5};
        tv[7]  = '{-33'sd7, 33'd0, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFF9};
        tv[8]  = '{33'd9, 33'd3, 40'd3, 40'd0};
        tv[9]  = '{33'd0, 33'd5, 40'd0, 40'd0};
        tv[10] = '{-33'sd1, 33'd2, 40'd0, 40'hFF_FFFF_FFFF};
        tv[11] = '{33'h1_0000_0000, 33'd1, 40'hFF_0000_0000, 40'd0};
        tv[12] = '{33'h0_FFFF_FFFF, 33'h1_0000_0000, 40'd0, 40'h00_FFFF_FFFF};
        tv[13] = '{33'd3, 33'd5, 40'd0, 40'd3};

        bus.s_axis_dividend_tvalid = 1'b0;
        bus.s_axis_divisor_tvalid  = 1'b0;
        bus.s_axis_dividend_tdata  = '0;
        bus.s_axis_divisor_tdata   = '0;

        repeat (3) @(negedge clk);
        chk("rst_dividend_tready", 64'(bus.s_axis_dividend_tready), 64'd0);
        chk("rst_divisor_tready", 64'(bus.s_axis_divisor_tready), 64'd0);
        chk("rst_tvalid", 64'(bus.m_axis_dout_tvalid), 64'd0);
        chk("rst_tdata", 64'(bus.m_axis_dout_tdata[63:0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_dividend_tready", 64'(bus.s_axis_dividend_tready), 64'd1);
        chk("post_rst_divisor_tready", 64'(bus.s_axis_divisor_tready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            send(1'b1, 1'b1, tv[i].a, tv[i].b, hc);
            sb.push_back('{tv[i].q, tv[i].r, hc + 36});
            drain();
            @(negedge clk);
            chk("hold_tvalid", 64'(bus.m_axis_dout_tvalid), 64'd0);
            chk("hold_tdata", 64'(bus.m_axis_dout_tdata[79:16]), 64'({tv[i].q, tv[i].r} >> 16));
        end

        // Staggered channels: divisor first, dividend five cycles later.
        send(1'b0, 1'b1, 33'd0, -33'sd5, hc);
        chk("stagger_divisor_tready", 64'(bus.s_axis_divisor_tready), 64'd0);
        chk("stagger_dividend_tready", 64'(bus.s_axis_dividend_tready), 64'd1);
        repeat (3) @(negedge clk);
        send(1'b1, 1'b0, 33'd77, 33'd0, h2);
        chk("stagger_gap", 64'(h2 - hc), 64'd5);
        sb.push_back('{40'hFF_FFFF_FFF1, 40'd2, h2 + 36});
        drain();

        // Second pair buffered during CALC; issues right after the first result.
        send(1'b1, 1'b1, 33'd1000, 33'd33, hc);
        sb.push_back('{40'd30, 40'd10, hc + 36});
        repeat (8) @(negedge clk);
        send(1'b1, 1'b1, -33'sd50, 33'd6, h2);
        sb.push_back('{40'hFF_FFFF_FFF8, 40'hFF_FFFF_FFFE, hc + 72});
        chk("buf_dividend_tready", 64'(bus.s_axis_dividend_tready), 64'd0);
        chk("buf_divisor_tready", 64'(bus.s_axis_divisor_tready), 64'd0);
        while (cyc < hc + 37) @(negedge clk);
        chk("buf_tready_before_load", 64'({bus.s_axis_dividend_tready, bus.s_axis_divisor_tready}), 64'd0);
        @(negedge clk);
        chk("buf_tready_after_load", 64'({bus.s_axis_dividend_tready, bus.s_axis_divisor_tready}), 64'd3);
        drain();

        // Reset in the middle of an operation discards it.
        send(1'b1, 1'b1, 33'd100, 33'd7, hc);
        while (cyc < hc + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tready", 64'({bus.s_axis_dividend_tready, bus.s_axis_divisor_tready}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_after_tready", 64'({bus.s_axis_dividend_tready, bus.s_axis_divisor_tready}), 64'd3);
        chk("midrst_tdata", 64'(bus.m_axis_dout_tdata[63:0]), 64'd0);
        repeat (45) @(negedge clk);
        send(1'b1, 1'b1, 33'd9, 33'd3, hc);
        sb.push_back('{40'd3, 40'd0, hc + 36});
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
